// File: rtl/id_operand_sb_pkg.sv
// Shared decode-stage defines: reset/enable levels, default bus widths and the NOP encodings.
// Included by the operand resolver and the ID/EX boundary.
package id_operand_sb_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int AluOpBus   = 8;

   localparam logic                  RstEnable    = 1'b1;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  ReadEnable   = 1'b1;
   localparam logic                  ReadDisable  = 1'b0;
   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'b0000_0000;

endpackage

// File: rtl/id_src_resolve.sv
// Resolves one source operand: immediate, r0, forwarding (youngest first), writeback bypass, scoreboard, regfile.
// Purely combinational; a hazard means the operand cannot be produced this cycle.
module id_src_resolve
   import id_operand_sb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_STAGES = 2
) (
   input  logic                         re,
   input  logic [REG_ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]            rf_data,
   input  logic [DATA_W-1:0]            imm,
   input  logic [FWD_STAGES-1:0]        fwd_wreg,
   input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_wd,
   input  logic [FWD_STAGES*DATA_W-1:0] fwd_wdata,
   input  logic [FWD_STAGES-1:0]        fwd_dvalid,
   input  logic                         wb_we,
   input  logic [REG_ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]            wb_data,
   input  logic                         sb_busy,
   output logic [DATA_W-1:0]            data,
   output logic                         hazard
);

   logic              fwd_hit;
   logic              fwd_ok;
   logic [DATA_W-1:0] fwd_data;

   // Scan from the youngest stage; the first match shadows any older one.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_ok   = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
         if (!fwd_hit && fwd_wreg[k] && (fwd_wd[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
            fwd_hit  = 1'b1;
            fwd_ok   = fwd_dvalid[k];
            fwd_data = fwd_wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      data   = '0;
      hazard = 1'b0;
      if (re == ReadDisable) begin
         data = imm;
      end else if (addr == '0) begin
         data = '0;
      end else if (fwd_hit) begin
         data   = fwd_data;
         hazard = ~fwd_ok;
      end else if (wb_we && (wb_addr == addr)) begin
         data = wb_data;
      end else if (sb_busy) begin
         hazard = 1'b1;
      end else begin
         data = rf_data;
      end
   end

endmodule

// File: rtl/id_operand_sb.sv
// Decode-stage operand resolution with a pending-write scoreboard and the registered ID/EX boundary.
// 1 cycle issue-to-ex_valid_o; stalls on unresolved hazards, holds on ~ex_ready_i. Option SB_PERF_CNT_EN adds stall_cnt_o.
module id_operand_sb
   import id_operand_sb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int ALUOP_W    = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            id_valid_i,
   input  logic [NUM_SRC-1:0]              src_re_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]   src_addr_i,
   input  logic [NUM_SRC*DATA_W-1:0]       src_rf_data_i,
   input  logic [DATA_W-1:0]               imm_i,
   input  logic [REG_ADDR_W-1:0]           wd_i,
   input  logic                            wreg_i,
   input  logic                            long_lat_i,
   input  logic [ALUOP_W-1:0]              aluop_i,
   input  logic [FWD_STAGES-1:0]           fwd_wreg_i,
   input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_wd_i,
   input  logic [FWD_STAGES*DATA_W-1:0]    fwd_wdata_i,
   input  logic [FWD_STAGES-1:0]           fwd_dvalid_i,
   input  logic                            wb_we_i,
   input  logic [REG_ADDR_W-1:0]           wb_addr_i,
   input  logic [DATA_W-1:0]               wb_data_i,
   input  logic                            flush_i,
   input  logic                            ex_ready_i,
   output logic                            stallreq_o,
   output logic                            ex_valid_o,
   output logic [NUM_SRC*DATA_W-1:0]       ex_src_o,
   output logic [REG_ADDR_W-1:0]           ex_wd_o,
   output logic                            ex_wreg_o,
   output logic [ALUOP_W-1:0]              ex_aluop_o
`ifdef SB_PERF_CNT_EN
   ,
   output logic [31:0]                     stall_cnt_o
`endif
);

   localparam int SB_DEPTH = 2**REG_ADDR_W;

   logic [SB_DEPTH-1:0]       sb;
   logic [SB_DEPTH-1:0]       sb_next;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_hazard;
   logic                      hazard;
   logic                      issue;
   logic                      sb_set;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      id_src_resolve #(
         .DATA_W     (DATA_W),
         .REG_ADDR_W (REG_ADDR_W),
         .FWD_STAGES (FWD_STAGES)
      ) u_resolve (
         .re         (src_re_i[s]),
         .addr       (src_addr_i[s*REG_ADDR_W +: REG_ADDR_W]),
         .rf_data    (src_rf_data_i[s*DATA_W +: DATA_W]),
         .imm        (imm_i),
         .fwd_wreg   (fwd_wreg_i),
         .fwd_wd     (fwd_wd_i),
         .fwd_wdata  (fwd_wdata_i),
         .fwd_dvalid (fwd_dvalid_i),
         .wb_we      (wb_we_i),
         .wb_addr    (wb_addr_i),
         .wb_data    (wb_data_i),
         .sb_busy    (sb[src_addr_i[s*REG_ADDR_W +: REG_ADDR_W]]),
         .data       (src_data[s*DATA_W +: DATA_W]),
         .hazard     (src_hazard[s])
      );
   end

   assign hazard     = |src_hazard;
   assign stallreq_o = id_valid_i & hazard & (rst != RstEnable);
   assign issue      = id_valid_i & ~hazard & (ex_ready_i | ~ex_valid_o);
   assign sb_set     = issue & long_lat_i & (wreg_i == WriteEnable) & (wd_i != NOPRegAddr[REG_ADDR_W-1:0]);

   // Set is applied after clear: a freshly issued writer is younger than the one retiring.
   always_comb begin
      sb_next = sb;
      if (wb_we_i) sb_next[wb_addr_i] = 1'b0;
      if (sb_set)  sb_next[wd_i]      = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         sb <= '0;
      end else if (flush_i) begin
         sb <= '0;
      end else begin
         sb <= sb_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         ex_valid_o <= 1'b0;
         ex_src_o   <= '0;
         ex_wd_o    <= '0;
         ex_wreg_o  <= WriteDisable;
         ex_aluop_o <= ALUOP_W'(EXE_NOP_OP);
      end else if (flush_i) begin
         ex_valid_o <= 1'b0;
         ex_wreg_o  <= WriteDisable;
      end else if (issue) begin
         ex_valid_o <= 1'b1;
         ex_src_o   <= src_data;
         ex_wd_o    <= wd_i;
         ex_wreg_o  <= wreg_i;
         ex_aluop_o <= aluop_i;
      end else if (ex_ready_i) begin
         ex_valid_o <= 1'b0;
         ex_wreg_o  <= WriteDisable;
      end
   end

`ifdef SB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         stall_cnt_o <= '0;
      end else if (stallreq_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_operand_sb.sv
// Directed bench for id_operand_sb: forwarding priority, scoreboard stalls, backpressure and flush.
module tb_id_operand_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 2;
   localparam int FS = 2;
   localparam int OW = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           id_valid;
   logic [NS-1:0]  src_re;
   logic [NS*AW-1:0] src_addr;
   logic [NS*DW-1:0] src_rf_data;
   logic [DW-1:0]  imm;
   logic [AW-1:0]  wd;
   logic           wreg;
   logic           long_lat;
   logic [OW-1:0]  aluop;
   logic [FS-1:0]  fwd_wreg;
   logic [FS*AW-1:0] fwd_wd;
   logic [FS*DW-1:0] fwd_wdata;
   logic [FS-1:0]  fwd_dvalid;
   logic           wb_we;
   logic [AW-1:0]  wb_addr;
   logic [DW-1:0]  wb_data;
   logic           flush;
   logic           ex_ready;
   logic           stallreq;
   logic           ex_valid;
   logic [NS*DW-1:0] ex_src;
   logic [AW-1:0]  ex_wd;
   logic           ex_wreg;
   logic [OW-1:0]  ex_aluop;
`ifdef SB_PERF_CNT_EN
   logic [31:0]    stall_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_operand_sb #(
      .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .ALUOP_W(OW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid_i    (id_valid),
      .src_re_i      (src_re),
      .src_addr_i    (src_addr),
      .src_rf_data_i (src_rf_data),
      .imm_i         (imm),
      .wd_i          (wd),
      .wreg_i        (wreg),
      .long_lat_i    (long_lat),
      .aluop_i       (aluop),
      .fwd_wreg_i    (fwd_wreg),
      .fwd_wd_i      (fwd_wd),
      .fwd_wdata_i   (fwd_wdata),
      .fwd_dvalid_i  (fwd_dvalid),
      .wb_we_i       (wb_we),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data),
      .flush_i       (flush),
      .ex_ready_i    (ex_ready),
      .stallreq_o    (stallreq),
      .ex_valid_o    (ex_valid),
      .ex_src_o      (ex_src),
      .ex_wd_o       (ex_wd),
      .ex_wreg_o     (ex_wreg),
      .ex_aluop_o    (ex_aluop)
`ifdef SB_PERF_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0; src_re = '0; src_addr = '0; src_rf_data = '0; imm = '0;
      wd = '0; wreg = 1'b0; long_lat = 1'b0; aluop = '0;
      fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; fwd_dvalid = '0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
   endtask

   task automatic instr(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] dst, input logic ll);
      id_valid = 1'b1; src_re = re; src_addr = {a1, a0}; src_rf_data = {d1, d0};
      wd = dst; wreg = 1'b1; long_lat = ll; aluop = {3'b000, dst};
   endtask

   initial begin
      // Reset with a would-be hazard present: stall must stay low.
      idle();
      rst = 1'b1;
      instr(2'b01, 5'd4, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0);
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd4}; fwd_dvalid = 2'b00;
      #1 chk("stall_in_rst", {31'b0, stallreq}, 32'd0);
      tick(); tick();
      chk("rst_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_src0", ex_src[31:0], 32'd0);
      chk("rst_src1", ex_src[63:32], 32'd0);
      chk("rst_wd", {27'b0, ex_wd}, 32'd0);
      chk("rst_wreg", {31'b0, ex_wreg}, 32'd0);
      chk("rst_aluop", {24'b0, ex_aluop}, 32'd0);
      idle(); rst = 1'b0;
      tick();

      // ori r3 <- r1 | imm
      instr(2'b01, 5'd1, 5'd0, 32'h10, 32'h0, 5'd3, 1'b0);
      imm = 32'h55;
      tick();
      chk("ori_valid", {31'b0, ex_valid}, 32'd1);
      chk("ori_src0", ex_src[31:0], 32'h10);
      chk("ori_src1_imm", ex_src[63:32], 32'h55);
      chk("ori_wd", {27'b0, ex_wd}, 32'd3);
      chk("ori_wreg", {31'b0, ex_wreg}, 32'd1);
      chk("ori_aluop", {24'b0, ex_aluop}, 32'h03);

      // or reads r3 forwarded from EX
      idle();
      instr(2'b11, 5'd3, 5'd2, 32'h99, 32'h22, 5'd4, 1'b0);
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd3}; fwd_wdata = {32'h0, 32'h1234}; fwd_dvalid = 2'b01;
      #1 chk("fwd_nostall", {31'b0, stallreq}, 32'd0);
      tick();
      chk("fwd_src0", ex_src[31:0], 32'h1234);
      chk("fwd_src1_rf", ex_src[63:32], 32'h22);
      chk("fwd_wd", {27'b0, ex_wd}, 32'd4);

      // Both stages target r5: youngest wins
      idle();
      instr(2'b11, 5'd5, 5'd5, 32'h1, 32'h2, 5'd6, 1'b0);
      fwd_wreg = 2'b11; fwd_wd = {5'd5, 5'd5}; fwd_wdata = {32'hBBBB, 32'hAAAA}; fwd_dvalid = 2'b11;
      tick();
      chk("young_src0", ex_src[31:0], 32'hAAAA);
      chk("young_src1", ex_src[63:32], 32'hAAAA);

      // Load r7, then dependent reader stalls until writeback
      idle();
      instr(2'b01, 5'd1, 5'd0, 32'h100, 32'h0, 5'd7, 1'b1);
      tick();
      chk("ld_valid", {31'b0, ex_valid}, 32'd1);
      chk("ld_wd", {27'b0, ex_wd}, 32'd7);
      idle();
      instr(2'b01, 5'd7, 5'd0, 32'h70, 32'h0, 5'd8, 1'b0);
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd7}; fwd_dvalid = 2'b00;
      #1 chk("ld_stall_fwd", {31'b0, stallreq}, 32'd1);
      tick();
      chk("ld_bubble1", {31'b0, ex_valid}, 32'd0);
      fwd_wreg = 2'b00;
      #1 chk("ld_stall_sb", {31'b0, stallreq}, 32'd1);
      tick();
      chk("ld_bubble2", {31'b0, ex_valid}, 32'd0);
      wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
      #1 chk("wb_nostall", {31'b0, stallreq}, 32'd0);
      tick();
      chk("wb_valid", {31'b0, ex_valid}, 32'd1);
      chk("wb_src0", ex_src[31:0], 32'hCAFE);
      chk("wb_wd", {27'b0, ex_wd}, 32'd8);
      idle();
      instr(2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 5'd13, 1'b0);
      #1 chk("r7_cleared", {31'b0, stallreq}, 32'd0);
      tick();
      chk("r7_rf_src0", ex_src[31:0], 32'h77);

      // r0 ignores forwarding
      idle();
      instr(2'b11, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF, 5'd14, 1'b0);
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'hFFFF}; fwd_dvalid = 2'b01;
      #1 chk("r0_nostall", {31'b0, stallreq}, 32'd0);
      tick();
      chk("r0_src0", ex_src[31:0], 32'd0);
      chk("r0_src1", ex_src[63:32], 32'd0);

      // Backpressure from EX
      idle();
      instr(2'b01, 5'd1, 5'd0, 32'hA1, 32'h0, 5'd10, 1'b0);
      tick();
      chk("bp_a_wd", {27'b0, ex_wd}, 32'd10);
      idle();
      instr(2'b01, 5'd2, 5'd0, 32'hB2, 32'h0, 5'd11, 1'b0);
      ex_ready = 1'b0;
      #1 chk("bp_nostall", {31'b0, stallreq}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'b0, ex_valid}, 32'd1);
      chk("bp_hold_wd", {27'b0, ex_wd}, 32'd10);
      chk("bp_hold_src0", ex_src[31:0], 32'hA1);
      tick();
      chk("bp_hold2_wd", {27'b0, ex_wd}, 32'd10);
      ex_ready = 1'b1;
      tick();
      chk("bp_b_wd", {27'b0, ex_wd}, 32'd11);
      chk("bp_b_src0", ex_src[31:0], 32'hB2);
      idle();
      tick();
      chk("bp_bubble", {31'b0, ex_valid}, 32'd0);
      chk("bp_bubble_wreg", {31'b0, ex_wreg}, 32'd0);

      // r9 pending; flush during the stall clears it
      instr(2'b01, 5'd1, 5'd0, 32'h1, 32'h0, 5'd9, 1'b1);
      tick();
      chk("r9_valid", {31'b0, ex_valid}, 32'd1);
      idle();
      instr(2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 5'd15, 1'b0);
      #1 chk("r9_stall", {31'b0, stallreq}, 32'd1);
      flush = 1'b1;
      #1 chk("r9_stall_flush", {31'b0, stallreq}, 32'd1);
      tick();
      chk("flush_valid", {31'b0, ex_valid}, 32'd0);
      chk("flush_wreg", {31'b0, ex_wreg}, 32'd0);
      flush = 1'b0;
      #1 chk("r9_after_flush", {31'b0, stallreq}, 32'd0);
      tick();
      chk("r9_issue_valid", {31'b0, ex_valid}, 32'd1);
      chk("r9_issue_src0", ex_src[31:0], 32'h99);
      chk("r9_issue_wd", {27'b0, ex_wd}, 32'd15);

      // Same-cycle set and clear of r12: set wins
      idle();
      instr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12, 1'b1);
      wb_we = 1'b1; wb_addr = 5'd12;
      tick();
      chk("r12_valid", {31'b0, ex_valid}, 32'd1);
      idle();
      instr(2'b01, 5'd12, 5'd0, 32'h1212, 32'h0, 5'd16, 1'b0);
      #1 chk("r12_set_wins", {31'b0, stallreq}, 32'd1);
      tick();
      chk("r12_bubble", {31'b0, ex_valid}, 32'd0);
      idle();
      wb_we = 1'b1; wb_addr = 5'd12;
      tick();
      idle();
      instr(2'b01, 5'd12, 5'd0, 32'h1212, 32'h0, 5'd16, 1'b0);
      #1 chk("r12_cleared", {31'b0, stallreq}, 32'd0);
      tick();
      chk("r12_src0", ex_src[31:0], 32'h1212);
      chk("r12_wd", {27'b0, ex_wd}, 32'd16);

`ifdef SB_PERF_CNT_EN
      // Stalled cycles so far: two on r7, one on r9, one on r12
      chk("stall_cnt", stall_cnt, 32'd4);
`endif

      idle();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_operand_sb.md
Name: id_operand_sb

Overview:
- Parametrised successor of the decode-stage operand logic.
- Resolves NUM_SRC source operands through FWD_STAGES forwarding ports plus a writeback bypass.
- Tracks pending long-latency writes (loads, multi-cycle ops) in a per-register scoreboard, raises a stall request on unresolved hazards, and owns the registered ID/EX operand boundary with a valid/ready handshake.
- Sits between the instruction decoder and the EX stage.

Parameters:
- DATA_W, 32, operand/register width
- REG_ADDR_W, 5, register address width; scoreboard depth is 2**REG_ADDR_W
- NUM_SRC, 2, number of source operands resolved per instruction
- FWD_STAGES, 2, number of forwarding stages; index 0 = youngest (EX), index FWD_STAGES-1 = oldest (MEM)
- ALUOP_W, 8, width of the aluop passthrough field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid_i  in  1  decoded instruction present
- src_re_i  in  NUM_SRC  per-source read enable
- src_addr_i  in  NUM_SRC*REG_ADDR_W  source register addresses
- src_rf_data_i  in  NUM_SRC*DATA_W  regfile read data
- imm_i  in  DATA_W  immediate, used for any source with read enable low
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  destination write enable
- long_lat_i  in  1  result not available from the EX forwarding port
- aluop_i  in  ALUOP_W  passthrough to EX
- fwd_wreg_i  in  FWD_STAGES  forwarding-stage write enables
- fwd_wd_i  in  FWD_STAGES*REG_ADDR_W  forwarding-stage destinations
- fwd_wdata_i  in  FWD_STAGES*DATA_W  forwarding-stage data
- fwd_dvalid_i  in  FWD_STAGES  forwarding data is final
- wb_we_i  in  1  writeback enable
- wb_addr_i  in  REG_ADDR_W  writeback address
- wb_data_i  in  DATA_W  writeback data
- flush_i  in  1  pipeline flush
- ex_ready_i  in  1  EX accepts a new instruction
- stallreq_o  out  1  combinational stall request to pipeline control
- ex_valid_o  out  1  ID/EX register holds a valid instruction
- ex_src_o  out  NUM_SRC*DATA_W  resolved operands
- ex_wd_o  out  REG_ADDR_W  destination register
- ex_wreg_o  out  1  destination write enable
- ex_aluop_o  out  ALUOP_W  aluop

Behaviour:
- Reset: all registered outputs are 0, and all scoreboard bits are clear. The synchronous reset takes priority over flush and issue.
- Per-source resolution (combinational), first matching rule wins:
  - a) read enable is 0: the source is imm_i.
  - b) address is 0: the source is 0 and never raises a hazard.
  - c) lowest index k with fwd_wreg_i[k] set and fwd_wd_i[k] equal to the address: if fwd_dvalid_i[k] is set, the source is fwd_wdata_i[k]; otherwise it is a hazard.
  - d) wb_we_i is set and wb_addr_i equals the address: the source is wb_data_i. This is the same-cycle bypass and overrides the scoreboard bit.
  - e) the scoreboard bit for the address is set: hazard.
  - f) otherwise the source is the regfile data.
- hazard = OR over all sources. stallreq_o = id_valid_i & hazard & ~rst.
- issue = id_valid_i & ~hazard & (ex_ready_i | ~ex_valid_o).
- ID/EX register updates, in priority order:
  - rst
  - flush_i: ex_valid_o and ex_wreg_o go to 0.
  - issue: capture the resolved operands, wd, wreg and aluop; ex_valid_o goes to 1.
  - ex_ready_i without issue: insert a bubble; ex_valid_o and ex_wreg_o go to 0, other fields are don't-care.
  - otherwise: hold.
- Latency: 1 cycle from issue to ex_valid_o.
- Scoreboard set: on issue with long_lat_i set, wreg_i set and wd_i nonzero, set the bit for wd_i.
- Scoreboard clear: wb_we_i clears the bit for wb_addr_i.
  - Set and clear of the same register in the same cycle: set wins, because the new writer is younger.
  - The bit for register 0 is never set.
- Flush: flush_i clears every scoreboard bit. Pipeline control asserts flush_i only when all older long-latency writes are discarded. Flush during a stall drops the stalled instruction's issue for that cycle.
- A back-to-back long-latency write to a busy register issues normally. The bit stays set until the younger writeback; WAW ordering is guaranteed by the in-order pipeline.

Optional Feature:
- Macro: SB_PERF_CNT_EN.
- When defined: adds output stall_cnt_o (out, 32).
  - Increments on every cycle with stallreq_o set.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst only; unaffected by flush_i.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared defines package holds:
  - RstEnable, ZeroWord, NOPRegAddr
  - WriteEnable/WriteDisable, ReadEnable/ReadDisable
  - RegBus/RegAddrBus widths and the EXE_NOP_OP encoding
- One sub-module, id_src_resolve: resolves a single source (rules a–f) and outputs its data and hazard. It is instantiated NUM_SRC times via generate.
- Scoreboard and ID/EX register stay in the top module.

Test Plan:
- Issue ori to r3, then an or reading r3 next cycle, with fwd0 = {wreg=1, wd=3, data=32'h1234, dvalid=1} → no stall; ex_src_o[0] = 32'h1234 one cycle later.
- fwd0 and fwd1 both target r5 (data 32'hAAAA / 32'hBBBB, both dvalid) → operand = 32'hAAAA, the youngest stage.
- Load to r7 issued with long_lat_i = 1; the next instruction reads r7 while fwd0 has dvalid = 0 → stallreq_o = 1 and a bubble is inserted (ex_valid_o = 0). Later, wb_we_i with addr 7 and data 32'hCAFE → the same cycle issues with operand 32'hCAFE, and the r7 bit clears.
- Source address 0 while fwd0 targets r0 with data 32'hFFFF → operand = 0, no stall.
- ex_ready_i = 0 while ex_valid_o = 1 and a new instruction is present → outputs hold; issue occurs the cycle ex_ready_i returns to 1.
- Scoreboard bit for r9 set, then flush_i pulses → bit clears, ex_valid_o = 0, and a reader of r9 issues with no stall. With SB_PERF_CNT_EN: 3 stall cycles give stall_cnt_o = 3.
